// File: rtl/serial_fa_arbiter_pkg.sv
// Shared definitions for the round-robin bit-serial adder/subtractor.
package serial_fa_arbiter_pkg;

  // Default operand/result width.
  localparam int WIDTH_DEF = 8;

  // Controller states. The unused code 2'd3 is treated as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_arbiter_fa1.sv
// Single-bit full-adder cell: the only arithmetic in the serial datapath.
module fa1 (
  input  logic xin,
  input  logic yin,
  input  logic zin,
  output logic sout,
  output logic cout
);

  // Sum and carry of three one-bit inputs.
  always_comb begin
    sout = xin ^ yin ^ zin;
    cout = (xin & yin) | (zin & (xin ^ yin));
  end

endmodule

// File: rtl/serial_fa_arbiter.sv
// Two-requester round-robin front end around one shared full-adder cell,
// running each accepted add/subtract LSB-first, one bit per cycle.
//
// Handshake: a requester raises reqN with stable operands and holds it until
// it sees gntN (a one-cycle pulse marking operand capture); it must drop reqN
// in that same cycle. Requests seen while busy are ignored, not queued. The
// result appears with a one-cycle done pulse and is held until the next done.
module serial_fa_arbiter
  import serial_fa_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             sub0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sub1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q;
  logic             op_sub_q, carry_q, last_gnt_q;
  logic [CW-1:0]    count_q;
  logic             gnt0_q, gnt1_q, done_q, done_id_q, cout_q, ovf_q;
  logic [WIDTH-1:0] sum_q;

  logic             sel_valid, sel_id;
  logic             fa_y, fa_sout, fa_cout;
  logic [WIDTH-1:0] sum_next;

  // Round-robin pick: a lone requester wins; on a tie the one not served last.
  always_comb begin
    sel_valid = req0 | req1;
    sel_id    = (req0 & req1) ? ~last_gnt_q : req1;
  end

  // Subtraction feeds the inverted B bit; the +1 comes from the initial carry.
  always_comb begin
    fa_y     = b_sh_q[0] ^ op_sub_q;
    sum_next = {fa_sout, sum_sh_q[WIDTH-1:1]};
  end

  fa1 u_fa1 (
    .xin  (a_sh_q[0]),
    .yin  (fa_y),
    .zin  (carry_q),
    .sout (fa_sout),
    .cout (fa_cout)
  );

  // Controller, arbiter state, shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      op_sub_q   <= 1'b0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      last_gnt_q <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          carry_q  <= fa_cout;
          sum_sh_q <= sum_next;
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          count_q  <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            ovf_q     <= carry_q ^ fa_cout;
            cout_q    <= fa_cout;
            sum_q     <= sum_next;
            done_id_q <= last_gnt_q;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          if (sel_valid) begin
            a_sh_q     <= sel_id ? a1 : a0;
            b_sh_q     <= sel_id ? b1 : b0;
            op_sub_q   <= sel_id ? sub1 : sub0;
            carry_q    <= sel_id ? sub1 : sub0;
            count_q    <= '0;
            last_gnt_q <= sel_id;
            gnt0_q     <= ~sel_id;
            gnt1_q     <= sel_id;
            state_q    <= ST_RUN;
          end
        end
      endcase
    end
  end

  // Busy covers RUN and DONE; the spare encoding counts as idle.
  always_comb begin
    busy     = (state_q == ST_RUN) || (state_q == ST_DONE);
    gnt0     = gnt0_q;
    gnt1     = gnt1_q;
    done     = done_q;
    done_id  = done_id_q;
    sum_out  = sum_q;
    cout_out = cout_q;
    ovf_out  = ovf_q;
  end

endmodule

// File: tb/tb_serial_fa_arbiter.sv
// Self-checking bench for serial_fa_arbiter: directed cases with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_serial_fa_arbiter;
  import serial_fa_arbiter_pkg::*;

  localparam int W = WIDTH_DEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         req0, sub0, req1, sub1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, done, done_id, cout_out, ovf_out;
  logic [W-1:0] sum_out;

  serial_fa_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
    .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .sum_out(sum_out), .cout_out(cout_out), .ovf_out(ovf_out)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Result of a whole operation from plain integer arithmetic: {ovf,cout,sum}.
  function automatic logic [W+1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sub);
    int ai, bi, r, ua, ub;
    logic c, o;
    logic [W-1:0] s;
    ai = $signed(a);
    bi = $signed(b);
    ua = int'(a);
    ub = int'(b);
    r  = sub ? ai - bi : ai + bi;
    o  = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    c  = sub ? (ua >= ub) : (ua + ub >= (1 << W));
    s  = sub ? W'(ua - ub) : W'(ua + ub);
    return {o, c, s};
  endfunction

  logic [W+2:0] exp_q[$];   // {owner, ovf, cout, sum} per accepted operation
  int           m_cyc;      // cycles left in current operation, 0 = idle
  logic         m_last, m_gnt0, m_gnt1, m_done, m_id, m_cout, m_ovf;
  logic [W-1:0] m_sum;

  always @(posedge clk) begin
    logic         pick;
    logic [W+2:0] e;
    if (rst) begin
      m_cyc = 0; m_last = 1'b1; m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_done = 1'b0;
      m_id = 1'b0; m_cout = 1'b0; m_ovf = 1'b0; m_sum = '0;
      exp_q.delete();
    end else begin
      m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_done = 1'b0;
      if (m_cyc == 0) begin
        if (req0 || req1) begin
          pick   = (req0 && req1) ? !m_last : req1;
          m_last = pick;
          exp_q.push_back({pick, pick ? calc(a1, b1, sub1) : calc(a0, b0, sub0)});
          m_gnt0 = !pick;
          m_gnt1 = pick;
          m_cyc  = W + 1;
        end
      end else begin
        m_cyc--;
        if (m_cyc == 1) begin
          e = exp_q.pop_front();
          {m_id, m_ovf, m_cout, m_sum} = e;
          m_done = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  task automatic compare_loop();
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("gnt0", gnt0, m_gnt0);
      chk("gnt1", gnt1, m_gnt1);
      chk("busy", busy, m_cyc != 0);
      chk("done", done, m_done);
      chk("done_id", done_id, m_id);
      chk("sum_out", sum_out, m_sum);
      chk("cout_out", cout_out, m_cout);
      chk("ovf_out", ovf_out, m_ovf);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One operation from one requester; checks grant and done latency.
  task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, output logic [W-1:0] s, output logic c,
                        output logic o, output logic did);
    int t0, n;
    if (id) begin a1 = a; b1 = b; sub1 = sub; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; sub0 = sub; req0 = 1'b1; end
    t0 = cyc + 1;
    n  = 0;
    do begin step(); n++; end while (!(id ? gnt1 : gnt0) && n < 40);
    chk("gnt_seen", id ? gnt1 : gnt0, 1'b1);
    chk("gnt_latency", cyc - t0, 0);
    req0 = 1'b0; req1 = 1'b0;
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    n = 0;
    do begin step(); n++; end while (!done && n < 40);
    chk("done_seen", done, 1'b1);
    chk("done_latency", cyc - t0, W);
    s = sum_out; c = cout_out; o = ovf_out; did = done_id;
  endtask

  // Both requesters raised together, each dropped on its own grant.
  task automatic both_req();
    int g0, g1, d[2], id[2], nd, n;
    a0 = 8'h11; b0 = 8'h22; sub0 = 1'b0;
    a1 = 8'h50; b1 = 8'h05; sub1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    g0 = -1; g1 = -1; nd = 0; n = 0;
    while (nd < 2 && n < 60) begin
      step(); n++;
      if (gnt0) begin req0 = 1'b0; g0 = cyc; end
      if (gnt1) begin req1 = 1'b0; g1 = cyc; end
      if (done) begin d[nd] = cyc; id[nd] = int'(done_id); nd++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("both_done_count", nd, 2);
    if (nd == 2) begin
      chk("both_r0_first", int'(g0 >= 0 && g0 < g1), 1);
      chk("both_first_id", id[0], 0);
      chk("both_second_id", id[1], 1);
      chk("both_spacing", d[1] - d[0], W + 2);
      chk("both_gnt1_after_done", g1 - d[0], 2);
    end
    repeat (2) step();
  endtask

  // ---------------- main ----------------
  initial begin
    logic [W-1:0] s;
    logic c, o, did;
    int ng, nd;
    rst = 1'b1; req0 = 0; req1 = 0; sub0 = 0; sub1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    fork compare_loop(); join_none
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum_out, 8'h00);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    step();

    run_op(1'b0, 8'h5A, 8'h3C, 1'b0, s, c, o, did);
    chk("t1_sum", s, 8'h96); chk("t1_cout", c, 0); chk("t1_ovf", o, 1); chk("t1_id", did, 0);
    step();
    run_op(1'b1, 8'h10, 8'h20, 1'b1, s, c, o, did);
    chk("t2_sum", s, 8'hF0); chk("t2_cout", c, 0); chk("t2_ovf", o, 0); chk("t2_id", did, 1);
    step();
    run_op(1'b1, 8'h80, 8'h01, 1'b1, s, c, o, did);
    chk("t3_sum", s, 8'h7F); chk("t3_cout", c, 1); chk("t3_ovf", o, 1);
    step();
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, s, c, o, did);
    chk("t4_sum", s, 8'h00); chk("t4_cout", c, 1); chk("t4_ovf", o, 0);
    step();

    // Tie handling right after reset, then again with last_gnt = 1.
    rst = 1'b1; step(); rst = 1'b0;
    both_req();
    both_req();

    // Reset during the 4th RUN cycle aborts the operation.
    a0 = 8'h33; b0 = 8'h44; sub0 = 1'b0; req0 = 1'b1;
    nd = 0;
    do begin step(); nd++; end while (!gnt0 && nd < 40);
    chk("abort_gnt", gnt0, 1'b1);
    req0 = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sum", sum_out, 8'h00);
    nd = 0;
    repeat (W + 4) begin step(); if (done) nd++; end
    chk("abort_no_done", nd, 0);
    run_op(1'b0, 8'h01, 8'h01, 1'b0, s, c, o, did);
    chk("after_abort_sum", s, 8'h02);
    step();

    // A req0 pulse while busy must be ignored.
    a0 = 8'h07; b0 = 8'h09; sub0 = 1'b0; req0 = 1'b1;
    ng = 0; nd = 0;
    repeat (2 * W + 6) begin
      step();
      if (gnt0) begin ng++; req0 = 1'b0; end
      if (done) nd++;
      if (busy && ng == 1 && cyc % 3 == 0) req0 = 1'b1;
      else if (ng >= 1 && !gnt0) req0 = 1'b0;
    end
    req0 = 1'b0;
    chk("pulse_gnt_count", ng, 1);
    chk("pulse_done_count", nd, 1);
    repeat (2) step();

    // Randomized traffic, checked cycle by cycle by the model.
    nd = 0;
    repeat (1500) begin
      step();
      if (done) nd++;
      if (gnt0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        a0 = W'($urandom); b0 = W'($urandom); sub0 = 1'($urandom_range(0, 1)); req0 = 1'b1;
      end
      if (gnt1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        a1 = W'($urandom); b1 = W'($urandom); sub1 = 1'($urandom_range(0, 1)); req1 = 1'b1;
      end
      if ($urandom_range(0, 400) == 0) begin
        rst = 1'b1; step(); rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("random_progress", int'(nd > 50), 1);
    repeat (W + 4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_fa_arbiter.md
Name: serial_fa_arbiter

Overview:
Shares one FA1 full-adder cell between two requesters as a round-robin-arbitrated, LSB-first bit-serial adder/subtractor.
Each accepted request runs WIDTH cycles through the single FA1 with a registered carry, then returns sum, carry-out and signed overflow with a one-cycle done pulse.
Sits between two low-throughput client blocks and the shared FA1 datapath, trading latency for area.

Parameters:
WIDTH, 8, operand and result width in bits (>=2); the counter width is derived as clog2(WIDTH), not a parameter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req0  input  1  requester 0 operation request; held until gnt0
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
sub0  input  1  requester 0 op: 0 = A+B, 1 = A-B
req1  input  1  requester 1 operation request; held until gnt1
a1  input  WIDTH  requester 1 operand A
b1  input  WIDTH  requester 1 operand B
sub1  input  1  requester 1 op
gnt0  output  1  one-cycle pulse: requester 0 operands captured
gnt1  output  1  one-cycle pulse: requester 1 operands captured
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse: result valid
done_id  output  1  requester that owns the current result (0/1)
sum_out  output  WIDTH  result, held until next done
cout_out  output  1  final FA1 carry; for sub = NOT borrow
ovf_out  output  1  two's-complement overflow

Behaviour:
- Reset (rst=1 at a rising edge):
  - state = IDLE; gnt0/gnt1/busy/done/done_id/cout_out/ovf_out = 0; sum_out = 0.
  - carry, count and shift registers are cleared; last_gnt = 1, so requester 0 wins first.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - Only req1 high: requester 1 is selected.
  - Only req0 high: requester 0 is selected.
  - Both high: the requester != last_gnt is selected.
  - On the edge that leaves IDLE:
    - capture the selected a/b/sub into a_sh, b_sh and op_sub; carry = sub; count = 0; last_gnt = selected id.
    - register gnt<id> = 1 for exactly the next cycle, which is also the first RUN cycle.
- RUN, one bit per cycle:
  - FA1 inputs: xin = a_sh[0], yin = b_sh[0] ^ op_sub, zin = carry.
  - On each edge: carry <= cout; sum_sh <= {sout, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right; count++.
  - On the bit where count == WIDTH-1:
    - latch ovf = zin ^ cout, cout_out = cout, sum_out = final {sout, sum_sh[WIDTH-1:1]}, done_id = owner.
    - go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Latency and throughput:
  - Request sampled at edge T0; done is high in cycle T0+WIDTH+1.
  - One operation per WIDTH+2 cycles.
- Requests while busy are ignored, not queued. A requester must drop req in the cycle it sees gnt; a req still high in IDLE is a new operation.
- Operand changes after gnt have no effect.
- sum_out, cout_out, ovf_out and done_id change only on the edge that enters DONE (or on reset).
- Reset mid-RUN or mid-DONE:
  - the operation is aborted and no done is produced.
  - outputs return to reset values; the requester must re-request.
- FA1 is the only adder logic; no parallel '+' is permitted in this block.

Decomposition:
- Shared header `include (`define/localparam), holding:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 decodes to IDLE);
  - default WIDTH.
- One sub-module instance: the existing FA1 full-adder cell (xin, yin, zin -> sout, cout).
- The FSM, arbiter and shift registers live in serial_fa_arbiter.

Test Plan:
- Reset, then req0 with a0=8'h5A, b0=8'h3C, sub0=0 -> gnt0 pulse next cycle; done after 9 cycles; sum_out=8'h96, cout_out=0, ovf_out=1, done_id=0.
- req1, a1=8'h10, b1=8'h20, sub1=1 -> sum_out=8'hF0, cout_out=0, ovf_out=0, done_id=1. Then a=8'h80, b=8'h01, sub=1 -> 8'h7F, cout_out=1, ovf_out=1.
- req0, a0=8'hFF, b0=8'h01, add -> sum_out=8'h00, cout_out=1, ovf_out=0.
- After reset, req0 and req1 asserted in the same cycle, each held until its gnt:
  - gnt0 then done (done_id=0); gnt1 comes in the IDLE cycle after that done, then done (done_id=1).
  - Exactly WIDTH+2 cycles between done pulses.
  - Repeat with both requesting again: requester 0 is granted (last_gnt=1).
- Assert rst during the 4th RUN cycle -> no done pulse; all outputs 0 the next cycle; a fresh req0 (8'h01+8'h01) -> sum_out=8'h02.
- req0 pulsed again during RUN -> ignored: no extra gnt0 and no extra done.
